// File: rtl/seq_div_unit_if.sv
// -----------------------------------------------------------------------------
// seq_div_unit_if
// Handshake and data bundle between the control sequencer and the DIV
// responder of the ALU.
//
//   start     sequencer -> divider  request pulse, honoured only when idle
//   dividend  sequencer -> divider  numerator (from Y)
//   divisor   sequencer -> divider  denominator (from the bus)
//   z_lo      divider -> sequencer  quotient, feeds ZLO
//   z_hi      divider -> sequencer  remainder, feeds ZHI
//   busy      divider -> sequencer  operation in flight
//   done      divider -> sequencer  one-cycle pulse, results valid
//   div_zero  divider -> sequencer  last accepted divisor was zero
//
// Modports: master = sequencer side, slave = divider side.
// -----------------------------------------------------------------------------
interface seq_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] z_lo;
    logic [WIDTH-1:0] z_hi;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, dividend, divisor,
        input  z_lo, z_hi, busy, done, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output z_lo, z_hi, busy, done, div_zero
    );
endinterface

// File: rtl/seq_div_unit.sv
// -----------------------------------------------------------------------------
// seq_div_unit
// Multi-cycle restoring divider used as the DIV responder in the ALU. One
// quotient bit is produced per clock; the quotient is returned on z_lo and the
// remainder on z_hi together with a single-cycle done pulse.
//
// Ports:
//   clk   in   system clock, rising edge
//   clr   in   asynchronous active-low reset
//   bus   slave modport of seq_div_unit_if (start, dividend, divisor in;
//         z_lo, z_hi, busy, done, div_zero out)
//
// Configuration macro:
//   DIV_SIGNED_EN  defined   -> signed two's-complement division, quotient
//                               truncated toward zero, remainder takes the
//                               dividend's sign
//                  undefined -> unsigned division
//
// Timing (WIDTH=32): accept at E0, iterations E1..E32, FIX at E33 writes the
// results and raises done, IDLE again at E34. A zero divisor goes straight
// to DONE on the accepting edge.
// -----------------------------------------------------------------------------
module seq_div_unit #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           clr,
    seq_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] dvd_q;      // dividend shifts out MSB-first, quotient shifts in at LSB
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] z_lo_q;
    logic [WIDTH-1:0] z_hi_q;
    logic             busy_q;
    logic             done_q;
    logic             div_zero_q;
`ifdef DIV_SIGNED_EN
    logic             q_neg_q;
    logic             r_neg_q;
`endif

    logic [WIDTH:0]   diff_d;
    logic             ge_d;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] dvd_d;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
        return neg ? -v : v;
    endfunction

`ifdef DIV_SIGNED_EN
    // Magnitude as an unsigned WIDTH-bit value; the most negative number
    // maps onto itself, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return cond_neg(v, v[WIDTH-1]);
    endfunction
`endif

    // One restoring step on the WIDTH+1-bit partial remainder. The trial
    // value is below 2*divisor, so the top bit of the difference is a
    // reliable borrow flag.
    always_comb begin
        diff_d = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
        ge_d   = ~diff_d[WIDTH];
        rem_d  = ge_d ? diff_d[WIDTH-1:0] : {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
        dvd_d  = {dvd_q[WIDTH-2:0], ge_d};
    end

    // Datapath registers: no reset, every value is loaded at accept.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.start) begin
            rem_q <= '0;
`ifdef DIV_SIGNED_EN
            dvd_q <= magnitude(bus.dividend);
            dvs_q <= magnitude(bus.divisor);
`else
            dvd_q <= bus.dividend;
            dvs_q <= bus.divisor;
`endif
        end else if (state_q == CALC) begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            z_lo_q     <= '0;
            z_hi_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
`ifdef DIV_SIGNED_EN
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        busy_q     <= 1'b1;
                        div_zero_q <= 1'b0;
                        cnt_q      <= CNT_W'(WIDTH - 1);
`ifdef DIV_SIGNED_EN
                        q_neg_q    <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        r_neg_q    <= bus.dividend[WIDTH-1];
`endif
                        if (bus.divisor == '0) begin
                            z_lo_q     <= '1;
                            z_hi_q     <= bus.dividend;
                            div_zero_q <= 1'b1;
                            done_q     <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                FIX: begin
`ifdef DIV_SIGNED_EN
                    z_lo_q <= cond_neg(dvd_q, q_neg_q);
                    z_hi_q <= cond_neg(rem_q, r_neg_q);
`else
                    z_lo_q <= dvd_q;
                    z_hi_q <= rem_q;
`endif
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.z_lo     = z_lo_q;
    assign bus.z_hi     = z_hi_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
endmodule
